// File: rtl/cordic_rot_iter_if.sv
// cordic_rot_iter_if: operand/result handshake bundle for cordic_rot_iter.
// The engine connects through the slave modport and its environment through
// the master modport. WORD_WIDTH must match the engine's WORD_WIDTH.
interface cordic_rot_iter_if #(
    parameter int WORD_WIDTH = 20
);
    logic signed [WORD_WIDTH-1:0] x_i;
    logic signed [WORD_WIDTH-1:0] y_i;
    logic signed [WORD_WIDTH-1:0] z_i;
    logic                         vld_i;
    logic                         rdy_o;
    logic signed [WORD_WIDTH-1:0] x_o;
    logic signed [WORD_WIDTH-1:0] y_o;
    logic signed [WORD_WIDTH-1:0] z_o;
    logic                         vld_o;
    logic                         rdy_i;

    // Engine side: consumes operands, produces results.
    modport slave (
        input  x_i, y_i, z_i, vld_i, rdy_i,
        output rdy_o, x_o, y_o, z_o, vld_o
    );

    // Environment side: supplies operands, accepts results.
    modport master (
        output x_i, y_i, z_i, vld_i, rdy_i,
        input  rdy_o, x_o, y_o, z_o, vld_o
    );
endinterface

// File: rtl/cordic_rot_iter.sv
// cordic_rot_iter: folded rotation-mode CORDIC. One shared micro-rotation
// datapath is stepped ITERS times over the registered (x, y, z).
// Optional macro CORDIC_ROT_GAIN_COMP_EN adds a COMP state that multiplies
// x and y by 1/K to remove the CORDIC gain (one extra cycle of latency).
module cordic_rot_iter #(
    parameter int WORD_WIDTH = 20,
    parameter int FRAC_BITS  = 16,
    parameter int ITERS      = 16
) (
    input  logic             clk,
    input  logic             rst,
    cordic_rot_iter_if.slave bus_io
);

    localparam int W     = WORD_WIDTH;
    localparam int EW    = WORD_WIDTH + 1;
    localparam int CNT_W = $clog2(ITERS + 1);
    localparam int TAB_N = 32'sd1 << CNT_W;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'sd1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 32'sd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
`ifdef CORDIC_ROT_GAIN_COMP_EN
        ST_COMP = 2'd2,
`endif
        ST_DONE = 2'd3
    } state_t;

    // 2^FRAC_BITS as a real, used to quantise elaboration-time constants.
    function automatic real frac_scale();
        real s;
        s = 1.0;
        for (int j = 32'sd0; j < FRAC_BITS; j++) begin
            s = s * 2.0;
        end
        return s;
    endfunction

    // round(atan(2^-i) * 2^FRAC_BITS), via the Taylor series (t <= 0.5 for i >= 1).
    function automatic int atan_q(input int i);
        real t;
        real t2;
        real term;
        real acc;
        t = 1.0;
        for (int j = 32'sd0; j < i; j++) begin
            t = t * 0.5;
        end
        if (i == 32'sd0) begin
            acc = 0.78539816339744830962;
        end else begin
            t2   = t * t;
            term = t;
            acc  = 0.0;
            for (int k = 32'sd0; k < 32'sd40; k++) begin
                if ((k % 32'sd2) == 32'sd0) begin
                    acc = acc + term / $itor(32'sd2 * k + 32'sd1);
                end else begin
                    acc = acc - term / $itor(32'sd2 * k + 32'sd1);
                end
                term = term * t2;
            end
        end
        return $rtoi(acc * frac_scale() + 0.5);
    endfunction

    // Shift term: (v + 2^(i-1)) >>> i, which degenerates to v for i = 0.
    // The add is one bit wider so the rounding offset itself never wraps.
    function automatic logic signed [W-1:0] sh_fn(
        input logic signed [W-1:0] v,
        input logic [CNT_W-1:0]    i
    );
        logic signed [EW-1:0] rnd;
        logic signed [EW-1:0] sum;
        rnd = EW'(32'sd1) << i;
        rnd = rnd >> 1;
        sum = {v[W-1], v} + rnd;
        sum = sum >>> i;
        return sum[W-1:0];
    endfunction

`ifdef CORDIC_ROT_GAIN_COMP_EN
    localparam int PW = 2 * WORD_WIDTH + 2;

    // round(2^FRAC_BITS / K), K = prod sqrt(1 + 2^-2i); sqrt by Newton iteration.
    function automatic int kinv_q();
        real p;
        real t;
        real s;
        p = 1.0;
        t = 1.0;
        for (int i = 32'sd0; i < ITERS; i++) begin
            p = p * (1.0 + t * t);
            t = t * 0.5;
        end
        s = p;
        for (int k = 32'sd0; k < 32'sd40; k++) begin
            s = 0.5 * (s + p / s);
        end
        return $rtoi(frac_scale() / s + 0.5);
    endfunction

    localparam int KINV_I = kinv_q();

    // round(v * KINV / 2^FRAC_BITS), round half up, wrapped to WORD_WIDTH.
    function automatic logic signed [W-1:0] gain_fn(input logic signed [W-1:0] v);
        logic signed [PW-1:0] prod;
        prod = PW'(v) * PW'(KINV_I) + (PW'(32'sd1) <<< (FRAC_BITS - 32'sd1));
        prod = prod >>> FRAC_BITS;
        return prod[W-1:0];
    endfunction
`endif

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic signed [W-1:0]    x_q;
    logic signed [W-1:0]    x_d;
    logic signed [W-1:0]    y_q;
    logic signed [W-1:0]    y_d;
    logic signed [W-1:0]    z_q;
    logic signed [W-1:0]    z_d;

    logic signed [W-1:0]    sh_x_s;
    logic signed [W-1:0]    sh_y_s;
    logic signed [W-1:0]    atan_s;
    logic signed [W-1:0]    atan_tab_s [TAB_N];

    // Arctangent table, padded to a power of two so cnt indexes it directly.
    for (genvar g = 0; g < TAB_N; g++) begin : g_atan
        localparam logic signed [W-1:0] ATAN_G = (g < ITERS) ? W'(atan_q(g)) : '0;
        assign atan_tab_s[g] = ATAN_G;
    end

    assign sh_x_s = sh_fn(x_q, cnt_q);
    assign sh_y_s = sh_fn(y_q, cnt_q);
    assign atan_s = atan_tab_s[cnt_q];

    // State and working registers; synchronous reset discards any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
        end
    end

    // Next-state decode and one micro-rotation (or gain step) per cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_io.vld_i == 1'b1) begin
                    x_d     = bus_io.x_i;
                    y_d     = bus_io.y_i;
                    z_d     = bus_io.z_i;
                    cnt_d   = '0;
                    state_d = ST_ITER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (z_q[W-1] == 1'b0) begin
                    x_d = x_q - sh_y_s;
                    y_d = y_q + sh_x_s;
                    z_d = z_q - atan_s;
                end else begin
                    x_d = x_q + sh_y_s;
                    y_d = y_q - sh_x_s;
                    z_d = z_q + atan_s;
                end
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) begin
`ifdef CORDIC_ROT_GAIN_COMP_EN
                    state_d = ST_COMP;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_ITER;
                end
            end
`ifdef CORDIC_ROT_GAIN_COMP_EN
            ST_COMP: begin
                x_d     = gain_fn(x_q);
                y_d     = gain_fn(y_q);
                state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                if (bus_io.rdy_i == 1'b1) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake flags are pure state decodes; rdy_o is held low during reset.
    assign bus_io.rdy_o = (state_q == ST_IDLE) && (rst == 1'b0);
    assign bus_io.vld_o = (state_q == ST_DONE);
    assign bus_io.x_o   = x_q;
    assign bus_io.y_o   = y_q;
    assign bus_io.z_o   = z_q;

endmodule
